// File: rtl/instr_mem_slave_pkg.sv
// Shared types and constants for the instruction-memory slave.
// The response record carries one delivered word through the read-latency pipe.
package imem_pkg;

  // Word width of the response record; the slave is built for RV32 fetch.
  localparam int IMEM_DATA_W = 32;

  // addi x0,x0,0 -- returned in place of data for faulting fetches.
  localparam logic [IMEM_DATA_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [IMEM_DATA_W-1:0] data;
  } imem_resp_t;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/instr_mem_slave_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory (slave).
//
// Handshake: a request is accepted on a rising edge where req_in and gnt_out are
// both high; gnt_out is a same-cycle combinational answer to req_in. Each accepted
// request produces exactly one rvalid_out pulse, in order, unless flushed by
// flush_in or by reset; rdata_out/err_out are only meaningful while rvalid_out is
// high. The master must keep addr_in stable while req_in is high and gnt_out low.
interface instr_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_in;
  logic [ADDR_W-1:0] addr_in;
  logic              flush_in;
  logic              gnt_out;
  logic              rvalid_out;
  logic [DATA_W-1:0] rdata_out;
  logic              err_out;

  modport master (
    output req_in,
    output addr_in,
    output flush_in,
    input  gnt_out,
    input  rvalid_out,
    input  rdata_out,
    input  err_out
  );

  modport slave (
    input  req_in,
    input  addr_in,
    input  flush_in,
    output gnt_out,
    output rvalid_out,
    output rdata_out,
    output err_out
  );

endinterface

// File: rtl/instr_mem_slave_resp_pipe.sv
// LATENCY-deep delay line for fetch responses. Stage 0 is loaded on the
// accepting edge; the last stage is the response presented to the master.
// Payload only advances behind a surviving valid bit, so the last stage keeps
// the most recently delivered word while the pipe is idle.
module imem_resp_pipe
  import imem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_in,
  input  imem_resp_t in_resp,
  output imem_resp_t out_resp
);

  imem_resp_t stage_q [LATENCY];

  // Shift responses one stage per cycle; flush kills everything but the new entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      // A request accepted on a flush edge belongs to the new path and is kept.
      stage_q[0].valid <= in_resp.valid;
      if (in_resp.valid) begin
        stage_q[0].err  <= in_resp.err;
        stage_q[0].data <= in_resp.data;
      end
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i].valid <= stage_q[i-1].valid & ~flush_in;
        if (stage_q[i-1].valid && !flush_in) begin
          stage_q[i].err  <= stage_q[i-1].err;
          stage_q[i].data <= stage_q[i-1].data;
        end
      end
    end
  end

  assign out_resp = stage_q[LATENCY-1];

endmodule

// File: rtl/instr_mem_slave.sv
// Synthesizable instruction-memory responder for the fetch req/gnt/rvalid bus.
// Reads are combinational from the array at the accepting edge and then delayed
// by LATENCY cycles; a counter limits how many responses may be in flight.
module instr_mem_slave
  import imem_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MEM_DEPTH       = 256,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter     INIT_FILE       = ""
) (
  input  logic                                 clk,
  input  logic                                 reset,
  instr_mem_slave_if.slave                     bus,
  input  logic                                 stall_in,
  input  logic                                 wr_en_in,
  input  logic [$clog2(MEM_DEPTH)-1:0]         wr_addr_in,
  input  logic [DATA_W-1:0]                    wr_data_in,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_out
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-3:0] word_full;
  logic [IDX_W-1:0]  word_idx;
  logic              addr_err;
  logic              accept;
  logic              retire;
  logic [CNT_W-1:0]  outstanding_q;
  imem_resp_t        acc_resp;
  imem_resp_t        resp_out;

  // Program-load port; never held off by stall or flush.
  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      mem[wr_addr_in] <= wr_data_in;
    end
  end

  assign word_full = bus.addr_in[ADDR_W-1:2];
  assign word_idx  = word_full[IDX_W-1:0];
  assign addr_err  = (bus.addr_in[1:0] != 2'b00) |
                     (word_full >= (ADDR_W-2)'(MEM_DEPTH));

  // No bypass: a retire in the same cycle does not free a slot for this grant.
  assign bus.gnt_out = reset & bus.req_in & ~stall_in &
                       (outstanding_q < CNT_W'(MAX_OUTSTANDING));

  assign accept = bus.req_in & bus.gnt_out;
  assign retire = resp_out.valid;

  // Build the response for the request being accepted; the array read happens
  // before this edge's write lands, giving read-before-write on a collision.
  always_comb begin
    acc_resp       = '0;
    acc_resp.valid = accept;
    acc_resp.err   = addr_err;
    acc_resp.data  = addr_err ? NOP : mem[word_idx];
  end

  imem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .reset    (reset),
    .flush_in (bus.flush_in),
    .in_resp  (acc_resp),
    .out_resp (resp_out)
  );

  // Track accepted-but-unanswered requests; a flush leaves only the new-path fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else if (bus.flush_in) begin
      outstanding_q <= accept ? CNT_W'(1) : '0;
    end else begin
      outstanding_q <= outstanding_q + CNT_W'(accept) - CNT_W'(retire);
    end
  end

  assign bus.rvalid_out  = resp_out.valid;
  assign bus.rdata_out   = resp_out.data;
  assign bus.err_out     = resp_out.err;
  assign outstanding_out = outstanding_q;

endmodule

// File: doc/instr_mem_slave.md
Name: instr_mem_slave

Overview:
- Parametrised instruction-memory slave for the fetch stage's req/gnt/rvalid handshake. It replaces hand-driven gnt_in/instr_rvalid_in/instr_rdata_in stimulus with a synthesizable responder.
- Features: configurable read latency, an outstanding-request limit, grant stall injection, and flush of in-flight responses on branch mispredict.
- Program words load through a side write port or an init file. Sits between fetch and the program store in both the bench and the FPGA top.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, instruction word width.
- MEM_DEPTH, 256, number of DATA_W words.
- LATENCY, 1, cycles from accepting edge to rvalid (range 1..8).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (range 1..LATENCY+1).
- INIT_FILE, "", hex file loaded with $readmemh at elaboration; empty means no load.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- req_in  in  1  fetch request.
- addr_in  in  ADDR_W  byte address of request.
- gnt_out  out  1  request accepted this cycle.
- rvalid_out  out  1  response valid, one-cycle pulse per accepted request.
- rdata_out  out  DATA_W  instruction word.
- err_out  out  1  response error, qualified by rvalid_out.
- stall_in  in  1  forces gnt_out low (wait-state injection).
- flush_in  in  1  discard all in-flight responses.
- wr_en_in  in  1  program-load write enable.
- wr_addr_in  in  $clog2(MEM_DEPTH)  word index.
- wr_data_in  in  DATA_W  word to write.
- outstanding_out  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.

Behaviour:
- **Reset** (reset low, async): gnt_out=0 (forced regardless of req_in), rvalid_out=0, rdata_out=0, err_out=0, outstanding_out=0, all pipeline stages invalid. Memory array is not cleared.
- **Grant:** combinational. gnt_out = req_in & ~stall_in & (outstanding < MAX_OUTSTANDING). If the counter is at max and a response retires this cycle, grant is still 0 (no bypass).
- **Accept:** req_in & gnt_out at a rising edge.
  - Word index = addr_in[ADDR_W-1:2].
  - err = (addr_in[1:0] != 0) | (index >= MEM_DEPTH).
  - data = err ? NOP : mem[index].
  - Result enters stage 0 of a LATENCY-deep delay line.
- **Response timing:** request accepted at edge N gives rvalid_out=1 with data/err from edge N+LATENCY-1 until edge N+LATENCY. The master samples it at edge N+LATENCY.
  - LATENCY=1 yields back-to-back responses, one per cycle.
  - Responses are returned strictly in order.
  - rdata_out and err_out hold their last value when rvalid_out=0.
- **Outstanding counter:**
  - +1 on accept, -1 on retire (rvalid_out high at edge).
  - Simultaneous accept and retire leaves it unchanged.
  - Never wraps; reaching MAX_OUTSTANDING+1 is a verification error.
- **Flush** (flush_in high at edge):
  - All in-flight valid bits clear, so rvalid_out is 0 the next cycle for every flushed request.
  - A request accepted at the same edge is kept (new-path fetch); the counter becomes 1 if accepted, else 0.
  - A response being retired at the flush edge counts as delivered.
  - Flush has no effect on gnt_out.
- **Write port:** mem[wr_addr_in] <= wr_data_in at the edge.
  - A read accepted at the same edge of the same word returns the old data (read-before-write).
  - Writes are never blocked by stall_in or flush_in.
- **Stall:** stall_in only suppresses new grants; in-flight responses continue.
- **Mid-operation reset:** all in-flight responses are discarded with no rvalid_out pulses, and the counter returns to 0.

Decomposition:
- Package imem_pkg:
  - NOP constant 32'h0000_0013 (addi x0,x0,0).
  - typedef struct packed {logic valid; logic err; logic [DATA_W-1:0] data;} imem_resp_t (DATA_W fixed at 32 in the package).
  - Localparam helpers for the counter width.
- Sub-module imem_resp_pipe:
  - Parametrised LATENCY-stage shift register of imem_resp_t.
  - Has a flush input that clears every valid bit.
  - Has async active-low reset.

Test Plan:
- Load mem[0..3] = 0x00108093, 0x00318193, 0x00420213, 0x00108133. With LATENCY=1, req_in held 1 with addr 0,4,8,12 on consecutive edges -> gnt_out=1 every cycle, rvalid_out for 4 consecutive cycles one cycle later, rdata in order, err_out=0.
- LATENCY=3, MAX_OUTSTANDING=2, req_in held 1 -> gnt_out drops after 2 accepts and outstanding_out=2; first rvalid_out at accept edge+2; gnt_out reasserts the cycle after the first retire.
- addr_in=0x0000_0006 and addr_in=0x0000_0400 (index 256, MEM_DEPTH=256) -> rvalid_out with err_out=1 and rdata_out=0x00000013 for each.
- LATENCY=3, two requests in flight, flush_in pulsed together with a new accept at addr 8 -> no responses for the flushed pair; outstanding_out=1; one rvalid_out with mem[2]=0x00420213.
- stall_in=1 for 3 cycles with req_in=1 -> gnt_out=0 for those 3 cycles, in-flight response still delivered; first grant on the cycle stall_in falls.
- reset driven low asynchronously mid-cycle with 2 in flight -> gnt_out, rvalid_out and outstanding_out go to 0 immediately, no responses after release; same-edge write/read of word 1 with 0xDEADBEEF returns the old 0x00318193.
